// File: rtl/cs150_down.sv
// cs150_down: 4-bit down counter with async clear/preset, synchronous load,
// count enable, combinational borrow and a registered terminal-count pulse.
`default_nettype none

module cs150_down #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             PR,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             TC
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] load_value;
    logic             at_zero;

    // Out-of-range load values saturate so Q never leaves the 0..MAX sequence.
    assign load_value = (D > c_max) ? c_max : D;
    assign at_zero    = (Q == c_zero);
    assign BO         = EN && at_zero;

    always_ff @(posedge clk or negedge CLR or negedge PR) begin
        if (!CLR) begin
            Q  <= c_zero;
            TC <= 1'b0;
        end else if (!PR) begin
            Q  <= c_max;
            TC <= 1'b0;
        end else if (LD) begin
            Q  <= load_value;
            TC <= 1'b0;
        end else if (EN) begin
            if (at_zero) begin
                Q  <= c_max;
                TC <= 1'b1;
            end else begin
                Q  <= Q - c_one;
                TC <= 1'b0;
            end
        end else begin
            TC <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cs150_down.sv
// Scoreboard bench for cs150_down: three instances (MAX = 15, 9, 11) share stimulus.
`default_nettype none

module tb_cs150_down;

    logic       clk = 1'b0;
    logic       CLR, PR, EN, LD;
    logic [3:0] D;
    logic [3:0] q15, q9, q11;
    logic       bo15, bo9, bo11;
    logic       tc15, tc9, tc11;

    int tests = 0;
    int fails = 0;

    cs150_down #(.WIDTH(4), .MAX(15)) u15 (
        .clk(clk), .CLR(CLR), .PR(PR), .EN(EN), .LD(LD), .D(D),
        .Q(q15), .BO(bo15), .TC(tc15));
    cs150_down #(.WIDTH(4), .MAX(9)) u9 (
        .clk(clk), .CLR(CLR), .PR(PR), .EN(EN), .LD(LD), .D(D),
        .Q(q9), .BO(bo9), .TC(tc9));
    cs150_down #(.WIDTH(4), .MAX(11)) u11 (
        .clk(clk), .CLR(CLR), .PR(PR), .EN(EN), .LD(LD), .D(D),
        .Q(q11), .BO(bo11), .TC(tc11));

    always #10 clk = ~clk;

    typedef struct packed {
        logic [3:0] q0, q1, q2;
        logic       t0, t1, t2;
    } exp_t;

    exp_t       sb[$];
    int         maxv [3] = '{15, 9, 11};
    logic [3:0] mq   [3];
    logic       mt   [3];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [3:0] qe, input logic te,
                            input logic [3:0] qo, input logic to, input logic bo);
        chk({tag, ".Q"}, qo, qe);
        chk({tag, ".TC"}, {3'b0, to}, {3'b0, te});
        chk({tag, ".BO"}, {3'b0, bo}, {3'b0, (EN && qe == 4'd0)});
    endtask

    task automatic chk_model(input string tag);
        chk_inst({tag, "/m15"}, mq[0], mt[0], q15, tc15, bo15);
        chk_inst({tag, "/m9"},  mq[1], mt[1], q9,  tc9,  bo9);
        chk_inst({tag, "/m11"}, mq[2], mt[2], q11, tc11, bo11);
    endtask

    task automatic async_clear();
        CLR = 1'b0;
        for (int k = 0; k < 3; k++) begin mq[k] = 4'd0; mt[k] = 1'b0; end
    endtask

    task automatic async_preset();
        PR = 1'b0;
        for (int k = 0; k < 3; k++) begin mq[k] = 4'(maxv[k]); mt[k] = 1'b0; end
    endtask

    // Advance the reference model one edge, queue its prediction, then compare.
    task automatic tick(input string tag);
        exp_t e;
        exp_t got;
        for (int k = 0; k < 3; k++) begin
            if (CLR && PR) begin
                if (LD) begin
                    mq[k] = (int'(D) > maxv[k]) ? 4'(maxv[k]) : D;
                    mt[k] = 1'b0;
                end else if (EN) begin
                    if (mq[k] == 4'd0) begin
                        mq[k] = 4'(maxv[k]);
                        mt[k] = 1'b1;
                    end else begin
                        mq[k] = mq[k] - 4'd1;
                        mt[k] = 1'b0;
                    end
                end else begin
                    mt[k] = 1'b0;
                end
            end
        end
        e = '{q0: mq[0], q1: mq[1], q2: mq[2], t0: mt[0], t1: mt[1], t2: mt[2]};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk_inst({tag, "/m15"}, got.q0, got.t0, q15, tc15, bo15);
        chk_inst({tag, "/m9"},  got.q1, got.t1, q9,  tc9,  bo9);
        chk_inst({tag, "/m11"}, got.q2, got.t2, q11, tc11, bo11);
    endtask

    initial begin
        PR = 1'b1; EN = 1'b0; LD = 1'b0; D = 4'd0;
        async_clear();
        #5;
        chk_model("reset");
        EN = 1'b1;
        #1;
        chk_model("reset_bo_follows_en");
        #20;
        CLR = 1'b1;

        // Free-run: wrap, full descent, second wrap for MAX=15; two wraps for MAX=9.
        for (int i = 0; i < 17; i++) tick("count");
        for (int i = 0; i < 9; i++) tick("count_to6");
        chk("q15_is_6", q15, 4'd6);

        #4;
        async_preset();
        #1;
        chk_model("async_preset");
        async_clear();
        #1;
        chk_model("clr_over_pr");
        #1;
        PR = 1'b1; CLR = 1'b1;
        tick("resume_after_release");

        // Clear during the TC-high cycle drops TC at once.
        #4;
        async_clear();
        #1;
        chk_model("clear_in_tc_cycle");
        #1;
        CLR = 1'b1;
        tick("wrap_after_clear");

        LD = 1'b1; D = 4'd9;
        tick("load9");
        D = 4'd14;
        tick("load14_clamp");
        D = 4'd0;
        tick("load0");
        D = 4'd5;
        tick("load_beats_wrap");
        D = 4'd0;
        tick("load0_again");

        LD = 1'b0; EN = 1'b0;
        for (int i = 0; i < 5; i++) tick("hold_at_zero");
        EN = 1'b1;
        #1;
        chk_model("bo_immediate");
        tick("wrap_from_hold");

        for (int i = 0; i < 40; i++) begin
            EN = 1'($urandom_range(0, 3) != 0);
            LD = 1'($urandom_range(0, 7) == 0);
            D  = 4'($urandom_range(0, 15));
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
